// File: rtl/selector.sv
// Minimum-metric survivor selector: picks the path of the lowest-metric state
// out of four and registers it with its traceback write pointer.
`timescale 1ns/1ps
module selector #(
    parameter int unsigned PATH_W   = 8,
    parameter int unsigned METRIC_W = 4,
    parameter int unsigned PTR_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                refresh,
    input  logic                valid_in,
    input  logic [PATH_W-1:0]   updated_selected_branch_at_00,
    input  logic [PATH_W-1:0]   updated_selected_branch_at_01,
    input  logic [PATH_W-1:0]   updated_selected_branch_at_10,
    input  logic [PATH_W-1:0]   updated_selected_branch_at_11,
    input  logic [METRIC_W-1:0] new_branch_metric_00,
    input  logic [METRIC_W-1:0] new_branch_metric_01,
    input  logic [METRIC_W-1:0] new_branch_metric_10,
    input  logic [METRIC_W-1:0] new_branch_metric_11,
    input  logic [PTR_W-1:0]    write_pointer_in,
    output logic [PATH_W-1:0]   selected_path,
    output logic [PTR_W-1:0]    write_pointer_out,
    output logic                valid_out
);

    logic [METRIC_W-1:0] w_a_metric;
    logic [METRIC_W-1:0] w_b_metric;
    logic [PATH_W-1:0]   w_a_path;
    logic [PATH_W-1:0]   w_b_path;
    logic [PATH_W-1:0]   w_win_path;

    logic [PATH_W-1:0]   r_selected_path;
    logic [PTR_W-1:0]    r_write_pointer;
    logic                r_valid;

    // Two-level compare tree; strict less-than keeps ties on the lower state index.
    always_comb begin
        w_a_metric = new_branch_metric_00;
        w_a_path   = updated_selected_branch_at_00;
        w_b_metric = new_branch_metric_10;
        w_b_path   = updated_selected_branch_at_10;
        w_win_path = updated_selected_branch_at_00;
        if (new_branch_metric_01 < new_branch_metric_00) begin
            w_a_metric = new_branch_metric_01;
            w_a_path   = updated_selected_branch_at_01;
        end
        if (new_branch_metric_11 < new_branch_metric_10) begin
            w_b_metric = new_branch_metric_11;
            w_b_path   = updated_selected_branch_at_11;
        end
        w_win_path = w_a_path;
        if (w_b_metric < w_a_metric) begin
            w_win_path = w_b_path;
        end
    end

    // Output registers: refresh clears, idle cycles hold data but drop valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_selected_path <= '0;
            r_write_pointer <= '0;
            r_valid         <= 1'b0;
        end else if (refresh) begin
            r_selected_path <= '0;
            r_write_pointer <= '0;
            r_valid         <= 1'b0;
        end else if (valid_in) begin
            r_selected_path <= w_win_path;
            r_write_pointer <= write_pointer_in;
            r_valid         <= 1'b1;
        end else begin
            r_valid         <= 1'b0;
        end
    end

    assign selected_path     = r_selected_path;
    assign write_pointer_out = r_write_pointer;
    assign valid_out         = r_valid;

endmodule

// File: tb/tb_selector.sv
// Bench for selector: a behavioural min-search model checked every negedge,
// plus directed vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_selector;

    logic       clk = 1'b0;
    logic       rst;
    logic       refresh;
    logic       valid_in;
    logic [7:0] p [4];
    logic [3:0] m [4];
    logic [2:0] wp_in;
    logic [7:0] selected_path;
    logic [2:0] write_pointer_out;
    logic       valid_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mdl_path;
    logic [2:0] mdl_wp;
    logic       mdl_valid;

    selector #(.PATH_W(8), .METRIC_W(4), .PTR_W(3)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .refresh                       (refresh),
        .valid_in                      (valid_in),
        .updated_selected_branch_at_00 (p[0]),
        .updated_selected_branch_at_01 (p[1]),
        .updated_selected_branch_at_10 (p[2]),
        .updated_selected_branch_at_11 (p[3]),
        .new_branch_metric_00          (m[0]),
        .new_branch_metric_01          (m[1]),
        .new_branch_metric_10          (m[2]),
        .new_branch_metric_11          (m[3]),
        .write_pointer_in              (wp_in),
        .selected_path                 (selected_path),
        .write_pointer_out             (write_pointer_out),
        .valid_out                     (valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lowest metric wins; scanning upward with strict < keeps the lowest index on ties.
    function automatic int min_state();
        int best = 0;
        for (int i = 1; i < 4; i++)
            if (m[i] < m[best]) best = i;
        return best;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || refresh) begin
            mdl_path  <= 8'h00;
            mdl_wp    <= 3'd0;
            mdl_valid <= 1'b0;
        end else if (valid_in) begin
            mdl_path  <= p[min_state()];
            mdl_wp    <= wp_in;
            mdl_valid <= 1'b1;
        end else begin
            mdl_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cmp_path",  32'(selected_path),     rst ? 32'd0 : 32'(mdl_path));
        chk("cmp_wp",    32'(write_pointer_out), rst ? 32'd0 : 32'(mdl_wp));
        chk("cmp_valid", 32'(valid_out),         rst ? 32'd0 : 32'(mdl_valid));
    end

    // Drive one cycle of inputs (state order 00,01,10,11), then sit 1 ns past the capturing edge.
    task automatic apply(input logic [31:0] paths, input logic [15:0] mets,
                         input logic [2:0] wp, input logic vld, input logic rfr);
        p[0] = paths[31:24]; p[1] = paths[23:16]; p[2] = paths[15:8]; p[3] = paths[7:0];
        m[0] = mets[15:12];  m[1] = mets[11:8];   m[2] = mets[7:4];   m[3] = mets[3:0];
        wp_in    = wp;
        valid_in = vld;
        refresh  = rfr;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] path,
                              input logic [2:0] wp, input logic vld);
        chk({name, "_path"},  32'(selected_path),     32'(path));
        chk({name, "_wp"},    32'(write_pointer_out), 32'(wp));
        chk({name, "_valid"}, 32'(valid_out),         32'(vld));
    endtask

    initial begin
        rst = 1'b1; refresh = 1'b0; valid_in = 1'b0; wp_in = 3'd0;
        for (int i = 0; i < 4; i++) begin p[i] = 8'h00; m[i] = 4'd0; end
        #2;
        expect_out("reset", 8'h00, 3'd0, 1'b0);
        #10 rst = 1'b0;

        apply(32'hAACCF00F, 16'h1234, 3'd0, 1'b1, 1'b0);
        expect_out("basic", 8'hAA, 3'd0, 1'b1);
        chk("model_basic", 32'(mdl_path), 32'h0000_00AA);

        apply(32'hFF00AA55, 16'h0F78, 3'd2, 1'b1, 1'b0);
        expect_out("min00", 8'hFF, 3'd2, 1'b1);
        apply(32'hFF00AA55, 16'hDEF0, 3'd5, 1'b1, 1'b0);
        expect_out("min11", 8'h55, 3'd5, 1'b1);

        apply(32'h00FFAA55, 16'h5555, 3'd3, 1'b1, 1'b0);
        expect_out("tie_all", 8'h00, 3'd3, 1'b1);
        chk("model_tie", 32'(mdl_path), 32'h0000_0000);
        apply(32'h00FFAA55, 16'h5555, 3'd3, 1'b1, 1'b1);
        expect_out("refresh", 8'h00, 3'd0, 1'b0);

        apply(32'h11223344, 16'h9331, 3'd4, 1'b1, 1'b0);
        expect_out("pre_idle", 8'h44, 3'd4, 1'b1);
        apply(32'h99887766, 16'h0000, 3'd7, 1'b0, 1'b0);
        expect_out("idle_hold", 8'h44, 3'd4, 1'b0);

        apply(32'h10203040, 16'h7292, 3'd7, 1'b1, 1'b0);
        expect_out("tie01", 8'h20, 3'd7, 1'b1);
        apply(32'h10203040, 16'h6633, 3'd0, 1'b1, 1'b0);
        expect_out("tie10", 8'h30, 3'd0, 1'b1);
        apply(32'hA1B2C3D4, 16'hFFFE, 3'd1, 1'b1, 1'b0);
        expect_out("max_metric", 8'hD4, 3'd1, 1'b1);

        // Refresh glitches that never straddle a rising edge must be ignored.
        p[0] = 8'h5A; p[1] = 8'hA5; p[2] = 8'h3C; p[3] = 8'hC3;
        m[0] = 4'd8;  m[1] = 4'd4;  m[2] = 4'd6;  m[3] = 4'd9;
        wp_in = 3'd6; valid_in = 1'b1;
        refresh = 1'b1; #2.5 refresh = 1'b0;
        expect_out("glitch_mid", 8'hD4, 3'd1, 1'b1);
        #2.5 refresh = 1'b1; #3 refresh = 1'b0;
        @(posedge clk); #1;
        expect_out("glitch", 8'hA5, 3'd6, 1'b1);

        apply(32'h0102A0B0, 16'h3321, 3'd6, 1'b1, 1'b0);
        expect_out("pre_rst", 8'hB0, 3'd6, 1'b1);
        p[3] = 8'hEE; wp_in = 3'd6;
        #1 rst = 1'b1;
        #1 expect_out("async_rst", 8'h00, 3'd0, 1'b0);
        @(posedge clk); #3 rst = 1'b0;
        #1 expect_out("rst_release", 8'h00, 3'd0, 1'b0);
        @(posedge clk); #1;
        apply(32'h7788CCDD, 16'h8899, 3'd2, 1'b1, 1'b0);
        expect_out("post_rst", 8'h77, 3'd2, 1'b1);

        apply(32'h7788CCDD, 16'h8899, 3'd2, 1'b0, 1'b0);
        expect_out("final_idle", 8'h77, 3'd2, 1'b0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
